// File: rtl/d_sram_bridge_if.sv
// SRAM-like data bus between the MEM-stage bridge (master) and the memory slave.
// The request side is driven by the bridge; addr_ok/data_ok/rdata come back from the slave.
interface d_sram_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, bus_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, bus_rdata
  );
endinterface

// File: rtl/d_sram_bridge.sv
// Data-side bridge: turns a one-cycle MEM-stage access into one req/addr_ok/data_ok
// bus transaction, stalls the pipeline meanwhile, and holds the load result until release.
module d_sram_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              data_en,
  input  logic [3:0]        data_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              d_stall,
  input  logic              longest_stall,
  d_sram_bridge_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Illegal enable patterns fall back to a full-word access.
  function automatic logic [1:0] size_of(input logic [3:0] wen);
    logic [1:0] sz;
    case (wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: sz = 2'd0;
      4'b0011, 4'b1100:                   sz = 2'd1;
      default:                            sz = 2'd2;
    endcase
    return sz;
  endfunction

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    size_d  = size_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (data_en) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          wr_d    = |data_wen;
          size_d  = size_of(data_wen);
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.data_addr_ok) state_d = WAIT;
      end
      WAIT: begin
        if (bus.data_data_ok) begin
          rdata_d = bus.bus_rdata;
          state_d = DONE;
        end
      end
      DONE: begin
        // Staying here while frozen keeps the same access from being reissued.
        if (!longest_stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.data_req   = (state_q == REQ);
  assign bus.data_wr    = wr_q;
  assign bus.data_size  = size_q;
  assign bus.data_addr  = addr_q;
  assign bus.data_wdata = wdata_q;

  assign data_rdata = rdata_q;
  assign d_stall    = data_en & (state_q != DONE);

endmodule

// File: tb/tb_d_sram_bridge.sv
// Directed bench for d_sram_bridge: a transaction-level model checked every cycle,
// plus literal expectations on the scripted scenarios.
module tb_d_sram_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        data_en;
  logic [3:0]  data_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] data_rdata;
  logic        d_stall;
  logic        longest_stall;
  logic        freeze;

  int n_chk = 0;
  int n_fail = 0;

  d_sram_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  d_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .data_en      (data_en),
    .data_wen     (data_wen),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .data_rdata   (data_rdata),
    .d_stall      (d_stall),
    .longest_stall(longest_stall),
    .bus          (bus.master)
  );

  always #5 clk = ~clk;

  // Hazard unit: global stall is this bridge's stall OR'd with any other freeze source.
  assign longest_stall = d_stall | freeze;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit          m_pending;   // access latched, not yet completed on the bus
  bit          m_accepted;  // slave has taken the address
  bit          m_finished;  // completed, waiting for the pipeline to advance
  logic [31:0] m_addr, m_wdata, m_rdata;
  bit          m_wr;
  logic [1:0]  m_size;

  function automatic logic [1:0] exp_size(input logic [3:0] wen);
    if ($countones(wen) == 1) return 2'd0;
    if (wen == 4'h3 || wen == 4'hC) return 2'd1;
    return 2'd2;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_pending  <= 1'b0;
      m_accepted <= 1'b0;
      m_finished <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_rdata    <= '0;
      m_wr       <= 1'b0;
      m_size     <= 2'd0;
    end else if (m_finished) begin
      if (!longest_stall) m_finished <= 1'b0;
    end else if (m_pending) begin
      if (!m_accepted) begin
        if (bus.data_addr_ok) m_accepted <= 1'b1;
      end else if (bus.data_data_ok) begin
        m_rdata    <= bus.bus_rdata;
        m_pending  <= 1'b0;
        m_accepted <= 1'b0;
        m_finished <= 1'b1;
      end
    end else if (data_en) begin
      m_pending <= 1'b1;
      m_addr    <= cpu_addr;
      m_wdata   <= cpu_wdata;
      m_wr      <= (data_wen != 4'h0);
      m_size    <= exp_size(data_wen);
    end
  end

  always @(negedge clk) begin
    chk("m_req",   {31'd0, bus.data_req}, {31'd0, m_pending && !m_accepted});
    chk("m_addr",  bus.data_addr, m_addr);
    chk("m_wdata", bus.data_wdata, m_wdata);
    chk("m_wr",    {31'd0, bus.data_wr}, {31'd0, m_wr});
    chk("m_size",  {30'd0, bus.data_size}, {30'd0, m_size});
    chk("m_rdata", data_rdata, m_rdata);
    chk("m_stall", {31'd0, d_stall}, {31'd0, data_en && !m_finished});
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic aok, input logic dok,
                      input logic [31:0] rd, input logic frz);
    @(posedge clk);
    #1;
    data_en           = en;
    data_wen          = wen;
    cpu_addr          = addr;
    cpu_wdata         = wdata;
    bus.data_addr_ok  = aok;
    bus.data_data_ok  = dok;
    bus.bus_rdata     = rd;
    freeze            = frz;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  int req_cnt;

  initial begin
    resetn = 1'b0;
    data_en = 1'b0; data_wen = 4'h0; cpu_addr = '0; cpu_wdata = '0; freeze = 1'b0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.bus_rdata = '0;

    // Reset state: d_stall follows data_en, everything else zero.
    step(1'b1, 4'h0, 32'h1000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("rst_dstall", {31'd0, d_stall}, 32'd1);
    chk("rst_req", {31'd0, bus.data_req}, 32'd0);
    chk("rst_rdata", data_rdata, 32'h0);
    idle();
    resetn = 1'b1;
    idle();

    // Word load, minimum latency.
    step(1'b1, 4'h0, 32'h1000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("wl_c0_stall", {31'd0, d_stall}, 32'd1);
    chk("wl_c0_req", {31'd0, bus.data_req}, 32'd0);
    step(1'b1, 4'h0, 32'h1000, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("wl_c1_req", {31'd0, bus.data_req}, 32'd1);
    chk("wl_c1_size", {30'd0, bus.data_size}, 32'd2);
    chk("wl_c1_wr", {31'd0, bus.data_wr}, 32'd0);
    chk("wl_c1_addr", bus.data_addr, 32'h1000);
    step(1'b1, 4'h0, 32'h1000, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    chk("wl_c2_req", {31'd0, bus.data_req}, 32'd0);
    chk("wl_c2_stall", {31'd0, d_stall}, 32'd1);
    step(1'b1, 4'h0, 32'h1000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("wl_c3_stall", {31'd0, d_stall}, 32'd0);
    chk("wl_c3_rdata", data_rdata, 32'hDEADBEEF);
    idle();

    // Byte store, addr_ok held off 3 cycles while CPU-side inputs wander.
    step(1'b1, 4'b0100, 32'h2002, 32'h00AA0000, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'b0011, 32'hFFFF0000 + i, 32'h12345678, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("bs_req", {31'd0, bus.data_req}, 32'd1);
      chk("bs_addr", bus.data_addr, 32'h2002);
      chk("bs_wr", {31'd0, bus.data_wr}, 32'd1);
      chk("bs_size", {30'd0, bus.data_size}, 32'd0);
      chk("bs_wdata", bus.data_wdata, 32'h00AA0000);
    end
    step(1'b1, 4'b0100, 32'h2002, 32'h00AA0000, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("bs_req4", {31'd0, bus.data_req}, 32'd1);
    step(1'b1, 4'b0100, 32'h2002, 32'h00AA0000, 1'b0, 1'b1, 32'h55555555, 1'b0);
    chk("bs_wait_req", {31'd0, bus.data_req}, 32'd0);
    step(1'b1, 4'b0100, 32'h2002, 32'h00AA0000, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("bs_done_stall", {31'd0, d_stall}, 32'd0);
    idle();

    // Freeze in DONE for 5 cycles, then release; next instruction must see IDLE.
    req_cnt = 0;
    step(1'b1, 4'h0, 32'h30, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    req_cnt += int'(bus.data_req);
    step(1'b1, 4'h0, 32'h30, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    req_cnt += int'(bus.data_req);
    step(1'b1, 4'h0, 32'h30, 32'h0, 1'b0, 1'b1, 32'h12345678, 1'b1);
    req_cnt += int'(bus.data_req);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'h0, 32'h30, 32'h0, 1'b0, 1'b0, 32'hCAFEF00D, 1'b1);
      req_cnt += int'(bus.data_req);
      chk("fz_stall", {31'd0, d_stall}, 32'd0);
      chk("fz_rdata", data_rdata, 32'h12345678);
    end
    step(1'b1, 4'h0, 32'h30, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    req_cnt += int'(bus.data_req);
    chk("fz_rel_stall", {31'd0, d_stall}, 32'd0);
    step(1'b1, 4'h0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    req_cnt += int'(bus.data_req);
    chk("fz_idle_stall", {31'd0, d_stall}, 32'd1);
    chk("fz_req_pulses", req_cnt, 32'd1);
    step(1'b1, 4'h0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("fz_next_addr", bus.data_addr, 32'h40);
    step(1'b1, 4'h0, 32'h40, 32'h0, 1'b0, 1'b1, 32'h00004040, 1'b0);
    step(1'b1, 4'h0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("fz_next_rdata", data_rdata, 32'h00004040);
    idle();

    // Back-to-back loads 0x10 then 0x14.
    step(1'b1, 4'h0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 4'h0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("bb_a_addr", bus.data_addr, 32'h10);
    step(1'b1, 4'h0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hAAAA0010, 1'b0);
    step(1'b1, 4'h0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("bb_a_rdata", data_rdata, 32'hAAAA0010);
    step(1'b1, 4'h0, 32'h14, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("bb_gap_req", {31'd0, bus.data_req}, 32'd0);
    chk("bb_gap_stall", {31'd0, d_stall}, 32'd1);
    step(1'b1, 4'h0, 32'h14, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("bb_b_req", {31'd0, bus.data_req}, 32'd1);
    chk("bb_b_addr", bus.data_addr, 32'h14);
    step(1'b1, 4'h0, 32'h14, 32'h0, 1'b0, 1'b1, 32'hBBBB0014, 1'b0);
    step(1'b1, 4'h0, 32'h14, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("bb_b_rdata", data_rdata, 32'hBBBB0014);
    idle();

    // Async reset during WAIT; a late data_ok after release must be ignored.
    step(1'b1, 4'b1111, 32'h50, 32'h77777777, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 4'b1111, 32'h50, 32'h77777777, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 4'b1111, 32'h50, 32'h77777777, 1'b0, 1'b0, 32'h0, 1'b0);
    #1 resetn = 1'b0;
    #1;
    chk("ar_req", {31'd0, bus.data_req}, 32'd0);
    chk("ar_addr", bus.data_addr, 32'h0);
    chk("ar_wdata", bus.data_wdata, 32'h0);
    chk("ar_wr", {31'd0, bus.data_wr}, 32'd0);
    chk("ar_rdata", data_rdata, 32'h0);
    chk("ar_stall", {31'd0, d_stall}, 32'd1);
    idle();
    resetn = 1'b1;
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h99999999, 1'b0);
    chk("ar_late_req", {31'd0, bus.data_req}, 32'd0);
    idle();
    chk("ar_late_rdata", data_rdata, 32'h0);
    chk("ar_late_req2", {31'd0, bus.data_req}, 32'd0);

    // Half store decode, plus data_ok coinciding with addr_ok being ignored.
    step(1'b1, 4'b1100, 32'h60, 32'hBEEF0000, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 4'b1100, 32'h60, 32'hBEEF0000, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("hd_size", {30'd0, bus.data_size}, 32'd1);
    chk("hd_wr", {31'd0, bus.data_wr}, 32'd1);
    step(1'b1, 4'b1100, 32'h60, 32'hBEEF0000, 1'b0, 1'b1, 32'h0, 1'b0);
    step(1'b1, 4'b1100, 32'h60, 32'hBEEF0000, 1'b0, 1'b0, 32'h0, 1'b0);
    idle();
    step(1'b1, 4'b0101, 32'h64, 32'h00FF00FF, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 4'b0101, 32'h64, 32'h00FF00FF, 1'b1, 1'b1, 32'h0BADBAD0, 1'b0);
    chk("il_size", {30'd0, bus.data_size}, 32'd2);
    step(1'b1, 4'b0101, 32'h64, 32'h00FF00FF, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("il_coinc_stall", {31'd0, d_stall}, 32'd1);
    step(1'b1, 4'b0101, 32'h64, 32'h00FF00FF, 1'b0, 1'b1, 32'h600DF00D, 1'b0);
    step(1'b1, 4'b0101, 32'h64, 32'h00FF00FF, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("il_rdata", data_rdata, 32'h600DF00D);
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
